sub_serial: RTL and testbench

SUB_SERIAL -- requirements
Module: sub_serial

---
 rtl/sub_serial_if.sv | 24 ++
 rtl/sub_serial.sv | 90 +++++++++
 tb/tb_sub_serial.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sub_serial_if.sv
// Operand/result bundle for the bit-serial subtractor; master issues start with a/b, slave returns status and results.
// No flow control: start is only sampled when the slave is idle.
interface sub_serial_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic [WIDTH-1:0] mag;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow, mag
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow, mag
   );
endinterface

// File: rtl/sub_serial.sv
// Bit-serial unsigned subtractor, LSB first; done pulses WIDTH+1 cycles after the accepted start.
// start is ignored while busy or done; results hold until the next operation completes.
module sub_serial #(
   parameter int WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   sub_serial_if.slave bus
);
   localparam int             CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  INC  = CW'(1);

   typedef enum logic [1:0] {IDLE, SHIFT, ABS, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, d_q;
   logic [WIDTH-1:0] diff_q, mag_q;
   logic [CW-1:0]    cnt_q;
   logic             br_q, borrow_q, busy_q, done_q;

   logic             a_bit, b_bit, d_bit, br_d;
   logic [WIDTH-1:0] mag_d;

   assign a_bit = a_q[0];
   assign b_bit = b_q[0];
   assign d_bit = a_bit ^ b_bit ^ br_q;
   assign br_d  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
   // Two's-complement negation of the raw difference when the final borrow is set.
   assign mag_d = br_q ? (~d_q + WIDTH'(1)) : d_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         d_q      <= '0;
         cnt_q    <= '0;
         br_q     <= 1'b0;
         diff_q   <= '0;
         mag_q    <= '0;
         borrow_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  d_q     <= '0;
                  cnt_q   <= '0;
                  br_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               d_q   <= {d_bit, d_q[WIDTH-1:1]};
               br_q  <= br_d;
               cnt_q <= cnt_q + INC;
               if (cnt_q == LAST) begin
                  state_q <= ABS;
               end
            end
            ABS: begin
               diff_q   <= d_q;
               borrow_q <= br_q;
               mag_q    <= mag_d;
               busy_q   <= 1'b0;
               done_q   <= 1'b1;
               state_q  <= DONE;
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.diff   = diff_q;
   assign bus.borrow = borrow_q;
   assign bus.mag    = mag_q;
endmodule

// File: tb/tb_sub_serial.sv
// Directed bench for sub_serial: a cycle-timeline reference model queues expected results on accepted starts
// and checks busy/done/results at every falling edge.
module tb_sub_serial;
   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] diff;
      logic         borrow;
      logic [W-1:0] mag;
   } res_t;

   logic clk = 1'b0;
   logic rst_n;

   sub_serial_if #(.WIDTH(W)) bus ();

   sub_serial #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   res_t sb[$];
   res_t held = '0;
   int   tmr = 0;
   int   vectors = 0;
   int   miscompares = 0;

   function automatic res_t expect_of(logic [W-1:0] a, logic [W-1:0] b);
      res_t r;
      r.diff   = a - b;
      r.borrow = (a < b);
      r.mag    = (a < b) ? (b - a) : (a - b);
      return r;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // tmr: 0 idle, 1..9 busy (after edges E0..E8), 10 done (after E9), back to idle at E10.
   always begin
      @(posedge clk);
      if (!rst_n) begin
         tmr  = 0;
         sb.delete();
         held = '0;
      end else if (tmr == 0) begin
         if (bus.start) begin
            sb.push_back(expect_of(bus.a, bus.b));
            tmr = 1;
         end
      end else if (tmr == 10) begin
         tmr = 0;
      end else begin
         tmr++;
      end
      @(negedge clk);
      check("busy", 32'(bus.busy), 32'(tmr >= 1 && tmr <= 9));
      check("done", 32'(bus.done), 32'(tmr == 10));
      if (tmr == 10 && sb.size() != 0) begin
         held = sb.pop_front();
      end
      check("diff",   32'(bus.diff),   32'(held.diff));
      check("borrow", 32'(bus.borrow), 32'(held.borrow));
      check("mag",    32'(bus.mag),    32'(held.mag));
   end

   task automatic op(logic [W-1:0] a, logic [W-1:0] b, bit scramble);
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (scramble && i < 9) begin
            bus.a = W'($urandom_range(0, 255));
            bus.b = W'($urandom_range(0, 255));
         end
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      op(8'd5,   8'd1,   1'b0);
      op(8'd1,   8'd5,   1'b0);
      op(8'd0,   8'd255, 1'b0);
      op(8'd255, 8'd0,   1'b0);
      op(8'h80,  8'h80,  1'b0);

      // start held high: accepted every 11 cycles, exactly three times.
      bus.a     = 8'd10;
      bus.b     = 8'd3;
      bus.start = 1'b1;
      repeat (33) @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);

      op(8'd200, 8'd77, 1'b1);
      op(8'd17,  8'd90, 1'b1);

      // Abort: reset sampled on the edge that ends the fourth SHIFT cycle.
      bus.a     = 8'd33;
      bus.b     = 8'd99;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);

      op(8'd10, 8'd3, 1'b0);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
